// File: rtl/mac_r_frame_sf_if.sv
// Bus bundle for the store-and-forward receive frame engine:
// PHY-side symbol stream plus the switch-side FIFO read ports.
interface mac_r_frame_sf_if #(
    parameter int CNT_W = 16
);
    logic             speed;
    logic             rx_dv;
    logic             rx_vld;
    logic [7:0]       rx_d;
    logic             data_fifo_rd;
    logic [7:0]       data_fifo_dout;
    logic             ptr_fifo_rd;
    logic [15:0]      ptr_fifo_dout;
    logic             ptr_fifo_empty;
    logic [CNT_W-1:0] frm_ok_cnt;
    logic [CNT_W-1:0] frm_drop_cnt;

    modport master (
        output speed, rx_dv, rx_vld, rx_d,
        output data_fifo_rd, ptr_fifo_rd,
        input  data_fifo_dout, ptr_fifo_dout, ptr_fifo_empty,
        input  frm_ok_cnt, frm_drop_cnt
    );

    modport slave (
        input  speed, rx_dv, rx_vld, rx_d,
        input  data_fifo_rd, ptr_fifo_rd,
        output data_fifo_dout, ptr_fifo_dout, ptr_fifo_empty,
        output frm_ok_cnt, frm_drop_cnt
    );
endinterface

// File: rtl/mac_r_frame_sf.sv
// MAC receive frame engine: preamble strip, CRC/length check, and
// store-and-forward buffering with rollback of rejected frames.
module mac_r_frame_sf #(
    parameter int DATA_DEPTH = 4096,
    parameter int PTR_DEPTH  = 32,
    parameter int MIN_LEN    = 64,
    parameter int MAX_LEN    = 1518,
    parameter bit DROP_BAD   = 1'b1,
    parameter int CNT_W      = 16
) (
    input logic             clk_sys,
    input logic             rstn_sys,
    mac_r_frame_sf_if.slave bus
);
    localparam int DAW = $clog2(DATA_DEPTH);
    localparam int PAW = $clog2(PTR_DEPTH);
    localparam logic [31:0] POLY    = 32'hEDB88320;
    localparam logic [31:0] RESIDUE = 32'hDEBB20E3;
    localparam logic [DAW:0] D_FULL = (DAW+1)'(DATA_DEPTH);
    localparam logic [PAW:0] P_FULL = (PAW+1)'(PTR_DEPTH);
    localparam logic [11:0] MIN_L   = 12'(MIN_LEN);
    localparam logic [11:0] MAX_L   = 12'(MAX_LEN);

    typedef enum logic [2:0] {
        S_WAIT_IDLE,
        S_IDLE,
        S_PRE,
        S_DATA,
        S_CHECK,
        S_DROP
    } state_t;

    state_t           state_q, state_d;
    logic             nib_have_q, nib_have_d;
    logic [3:0]       nib_q, nib_d;
    logic [2:0]       pre_cnt_q, pre_cnt_d;
    logic [11:0]      len_q, len_d;
    logic [31:0]      crc_q, crc_d;
    logic [DAW:0]     wr_ptr_q, wr_ptr_d;
    logic [DAW:0]     wr_cmt_q, wr_cmt_d;
    logic [DAW:0]     rd_ptr_q, rd_ptr_d;
    logic [PAW:0]     pwr_q, pwr_d;
    logic [PAW:0]     prd_q, prd_d;
    logic [7:0]       ddout_q, ddout_d;
    logic [15:0]      pdout_q, pdout_d;
    logic             empty_q, empty_d;
    logic [CNT_W-1:0] ok_cnt_q, ok_cnt_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    logic [7:0]  dmem [DATA_DEPTH];
    logic [15:0] pmem [PTR_DEPTH];

    logic        byte_vld;
    logic [7:0]  byte_val;
    logic        crc_err;
    logic        runt;
    logic        dfull;
    logic        pfull;
    logic        dwe;
    logic        pwe;
    logic        rollback;
    logic        ok_inc;
    logic        drop_inc;
    logic [2:0]  pre_base;
    logic [15:0] pword;

    function automatic logic [31:0] crc_byte(
        input logic [31:0] c,
        input logic [7:0]  b
    );
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int k = 0; k < 8; k++) begin
            r = r[0] ? ((r >> 1) ^ POLY) : (r >> 1);
        end
        return r;
    endfunction

    assign byte_vld = bus.rx_dv & bus.rx_vld & (bus.speed | nib_have_q);
    assign byte_val = bus.speed ? bus.rx_d : {bus.rx_d[3:0], nib_q};
    assign crc_err  = (crc_q != RESIDUE);
    assign runt     = (len_q < MIN_L);
    assign dfull    = ((wr_ptr_q - rd_ptr_q) == D_FULL);
    assign pfull    = ((pwr_q - prd_q) == P_FULL);
    assign pword    = {crc_err, runt, 2'b00, len_q};

    always_comb begin
        state_d    = state_q;
        nib_have_d = nib_have_q;
        nib_d      = nib_q;
        pre_cnt_d  = pre_cnt_q;
        len_d      = len_q;
        crc_d      = crc_q;
        wr_ptr_d   = wr_ptr_q;
        wr_cmt_d   = wr_cmt_q;
        rd_ptr_d   = rd_ptr_q;
        pwr_d      = pwr_q;
        prd_d      = prd_q;
        ddout_d    = ddout_q;
        pdout_d    = pdout_q;
        ok_cnt_d   = ok_cnt_q;
        drop_cnt_d = drop_cnt_q;
        dwe        = 1'b0;
        pwe        = 1'b0;
        rollback   = 1'b0;
        ok_inc     = 1'b0;
        drop_inc   = 1'b0;
        pre_base   = 3'd0;

        // Nibble pairing restarts at every frame envelope.
        if (!bus.rx_dv) begin
            nib_have_d = 1'b0;
        end else if (bus.rx_vld && !bus.speed) begin
            nib_have_d = ~nib_have_q;
            if (!nib_have_q) nib_d = bus.rx_d[3:0];
        end

        unique case (state_q)
            S_WAIT_IDLE: begin
                if (!bus.rx_dv) state_d = S_IDLE;
            end
            S_IDLE, S_PRE: begin
                pre_base = (state_q == S_IDLE) ? 3'd0 : pre_cnt_q;
                if (!bus.rx_dv) begin
                    state_d = S_IDLE;
                end else begin
                    state_d   = S_PRE;
                    pre_cnt_d = pre_base;
                    if (byte_vld) begin
                        if (byte_val == 8'h55 && pre_base != 3'd7) begin
                            pre_cnt_d = pre_base + 3'd1;
                        end else if (byte_val == 8'hD5 && pre_base != 3'd0) begin
                            if (pfull) begin
                                state_d  = S_DROP;
                                drop_inc = 1'b1;
                            end else begin
                                state_d  = S_DATA;
                                len_d    = 12'd0;
                                crc_d    = '1;
                                wr_ptr_d = wr_cmt_q;
                            end
                        end else begin
                            state_d = S_DROP;
                        end
                    end
                end
            end
            S_DATA: begin
                if (!bus.rx_dv) begin
                    state_d = S_CHECK;
                end else if (byte_vld) begin
                    if (dfull || len_q == MAX_L) begin
                        state_d  = S_DROP;
                        rollback = 1'b1;
                    end else begin
                        dwe      = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        len_d    = len_q + 12'd1;
                        crc_d    = crc_byte(crc_q, byte_val);
                    end
                end
            end
            S_CHECK: begin
                state_d = S_IDLE;
                if ((crc_err || runt) && DROP_BAD) begin
                    rollback = 1'b1;
                end else begin
                    pwe      = 1'b1;
                    pwr_d    = pwr_q + 1'b1;
                    wr_cmt_d = wr_ptr_q;
                    ok_inc   = ~(crc_err | runt);
                end
            end
            S_DROP: begin
                if (!bus.rx_dv) state_d = S_IDLE;
            end
            default: state_d = S_WAIT_IDLE;
        endcase

        if (rollback) begin
            wr_ptr_d = wr_cmt_q;
            drop_inc = 1'b1;
        end
        if (ok_inc && ok_cnt_q != '1) ok_cnt_d = ok_cnt_q + 1'b1;
        if (drop_inc && drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 1'b1;

        // The reader never passes the last committed byte.
        if (bus.data_fifo_rd && rd_ptr_q != wr_cmt_q) begin
            ddout_d  = dmem[rd_ptr_q[DAW-1:0]];
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (bus.ptr_fifo_rd && prd_q != pwr_q) begin
            pdout_d = pmem[prd_q[PAW-1:0]];
            prd_d   = prd_q + 1'b1;
        end
        // Pops show at once; a fresh commit shows one cycle later.
        empty_d = (pwr_q == prd_d);
    end

    always_ff @(posedge clk_sys or negedge rstn_sys) begin
        if (!rstn_sys) begin
            state_q    <= S_WAIT_IDLE;
            nib_have_q <= 1'b0;
            nib_q      <= '0;
            pre_cnt_q  <= '0;
            len_q      <= '0;
            crc_q      <= '1;
            wr_ptr_q   <= '0;
            wr_cmt_q   <= '0;
            rd_ptr_q   <= '0;
            pwr_q      <= '0;
            prd_q      <= '0;
            ddout_q    <= '0;
            pdout_q    <= '0;
            empty_q    <= 1'b1;
            ok_cnt_q   <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            nib_have_q <= nib_have_d;
            nib_q      <= nib_d;
            pre_cnt_q  <= pre_cnt_d;
            len_q      <= len_d;
            crc_q      <= crc_d;
            wr_ptr_q   <= wr_ptr_d;
            wr_cmt_q   <= wr_cmt_d;
            rd_ptr_q   <= rd_ptr_d;
            pwr_q      <= pwr_d;
            prd_q      <= prd_d;
            ddout_q    <= ddout_d;
            pdout_q    <= pdout_d;
            empty_q    <= empty_d;
            ok_cnt_q   <= ok_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (dwe) dmem[wr_ptr_q[DAW-1:0]] <= byte_val;
        if (pwe) pmem[pwr_q[PAW-1:0]] <= pword;
    end

    assign bus.data_fifo_dout = ddout_q;
    assign bus.ptr_fifo_dout  = pdout_q;
    assign bus.ptr_fifo_empty = empty_q;
    assign bus.frm_ok_cnt     = ok_cnt_q;
    assign bus.frm_drop_cnt   = drop_cnt_q;
endmodule

// File: tb/tb_mac_r_frame_sf.sv
// Bench for mac_r_frame_sf: two instances (reject-bad and keep-bad)
// share one receive stream and are compared against a frame-level model.
module tb_mac_r_frame_sf;
    logic       clk = 1'b0;
    logic       rstn;
    logic       speed;
    logic       rx_dv;
    logic       rx_vld;
    logic [7:0] rx_d;
    logic [1:0] drd;
    logic [1:0] prd;

    int errors = 0;
    int checks = 0;

    logic [7:0]  frm [$];
    logic [15:0] exp_ptr [2][$];
    logic [7:0]  exp_dat [2][$];
    int occ [2];
    int pcnt [2];
    int okc [2];
    int drc [2];

    always #5 clk = ~clk;

    mac_r_frame_sf_if #(.CNT_W(16)) if0 ();
    mac_r_frame_sf_if #(.CNT_W(16)) if1 ();

    assign if0.speed = speed;
    assign if0.rx_dv = rx_dv;
    assign if0.rx_vld = rx_vld;
    assign if0.rx_d = rx_d;
    assign if0.data_fifo_rd = drd[0];
    assign if0.ptr_fifo_rd = prd[0];
    assign if1.speed = speed;
    assign if1.rx_dv = rx_dv;
    assign if1.rx_vld = rx_vld;
    assign if1.rx_d = rx_d;
    assign if1.data_fifo_rd = drd[1];
    assign if1.ptr_fifo_rd = prd[1];

    mac_r_frame_sf #(.DROP_BAD(1'b1)) u_dut0 (
        .clk_sys  (clk),
        .rstn_sys (rstn),
        .bus      (if0)
    );

    mac_r_frame_sf #(.DROP_BAD(1'b0)) u_dut1 (
        .clk_sys  (clk),
        .rstn_sys (rstn),
        .bus      (if1)
    );

    function automatic logic [7:0] ddo(int w);
        return (w == 1) ? if1.data_fifo_dout : if0.data_fifo_dout;
    endfunction
    function automatic logic [15:0] pdo(int w);
        return (w == 1) ? if1.ptr_fifo_dout : if0.ptr_fifo_dout;
    endfunction
    function automatic logic pempty(int w);
        return (w == 1) ? if1.ptr_fifo_empty : if0.ptr_fifo_empty;
    endfunction
    function automatic logic [15:0] okcnt(int w);
        return (w == 1) ? if1.frm_ok_cnt : if0.frm_ok_cnt;
    endfunction
    function automatic logic [15:0] drcnt(int w);
        return (w == 1) ? if1.frm_drop_cnt : if0.frm_drop_cnt;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ethernet FCS definition: reflected CRC-32 over the frame body.
    function automatic logic [31:0] crc_of(int n);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'h0, frm[i]};
            for (int k = 0; k < 8; k++) begin
                c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            end
        end
        return c;
    endfunction

    task automatic build(int len, logic [47:0] da, logic [15:0] ty, bit bad);
        logic [31:0] fcs;
        frm.delete();
        for (int i = 0; i < 6; i++) frm.push_back(da[47-8*i -: 8]);
        for (int i = 0; i < 6; i++) frm.push_back(8'($urandom));
        frm.push_back(ty[15:8]);
        frm.push_back(ty[7:0]);
        while (frm.size() < len - 4) frm.push_back(8'($urandom));
        fcs = ~crc_of(len - 4);
        for (int b = 0; b < 4; b++) begin
            frm.push_back(fcs[8*b +: 8] ^ (bad ? 8'hFF : 8'h00));
        end
    endtask

    task automatic put(logic [7:0] s);
        if ($urandom_range(0, 7) == 0) begin
            rx_vld = 1'b0;
            rx_d = 8'($urandom);
            tick();
        end
        rx_vld = 1'b1;
        rx_d = s;
        tick();
    endtask

    task automatic send(bit nib, int npre, int rst_at);
        logic [7:0] s [$];
        for (int i = 0; i < npre; i++) s.push_back(8'h55);
        s.push_back(8'hD5);
        foreach (frm[i]) s.push_back(frm[i]);
        speed = ~nib;
        rx_dv = 1'b1;
        foreach (s[i]) begin
            if (i == rst_at) begin
                rstn = 1'b0;
                tick();
                tick();
                rstn = 1'b1;
            end
            if (nib) begin
                put({4'($urandom), s[i][3:0]});
                put({4'($urandom), s[i][7:4]});
            end else begin
                put(s[i]);
            end
        end
        rx_vld = 1'b0;
        rx_dv = 1'b0;
    endtask

    task automatic model_reset();
        for (int w = 0; w < 2; w++) begin
            exp_ptr[w].delete();
            exp_dat[w].delete();
            occ[w] = 0;
            pcnt[w] = 0;
            okc[w] = 0;
            drc[w] = 0;
        end
    endtask

    // Frame-level outcome: drop reasons in order, else commit.
    task automatic model_frame();
        int len;
        logic [31:0] fcs;
        bit fcs_ok;
        bit short_f;
        len = frm.size();
        fcs = ~crc_of(len - 4);
        fcs_ok = {frm[len-1], frm[len-2], frm[len-3], frm[len-4]} == fcs;
        short_f = len < 64;
        for (int w = 0; w < 2; w++) begin
            if (pcnt[w] >= 32) begin
                drc[w]++;
            end else if (len > 1518 || occ[w] + len > 4096) begin
                drc[w]++;
            end else if ((!fcs_ok || short_f) && w == 0) begin
                drc[w]++;
            end else begin
                exp_ptr[w].push_back({~fcs_ok, short_f, 2'b00, 12'(len)});
                foreach (frm[i]) exp_dat[w].push_back(frm[i]);
                occ[w] += len;
                pcnt[w]++;
                if (fcs_ok && !short_f) okc[w]++;
            end
        end
    endtask

    task automatic ifg();
        repeat (12) tick();
    endtask

    task automatic check_state(string tag);
        for (int w = 0; w < 2; w++) begin
            chk($sformatf("%s_ok_d%0d", tag, w), 32'(okcnt(w)), 32'(okc[w]));
            chk($sformatf("%s_drop_d%0d", tag, w), 32'(drcnt(w)), 32'(drc[w]));
            chk($sformatf("%s_empty_d%0d", tag, w), 32'(pempty(w)),
                32'(exp_ptr[w].size() == 0));
        end
    endtask

    task automatic drain(string tag, int w);
        int guard;
        int bad;
        int first;
        logic [15:0] pw;
        logic [7:0] e;
        guard = 0;
        while (exp_ptr[w].size() > 0 && guard < 64) begin
            guard++;
            chk($sformatf("%s_avail_d%0d", tag, w), 32'(pempty(w)), 32'd0);
            prd[w] = 1'b1;
            tick();
            prd[w] = 1'b0;
            pw = exp_ptr[w].pop_front();
            chk($sformatf("%s_ptr_d%0d", tag, w), 32'(pdo(w)), 32'(pw));
            bad = 0;
            first = -1;
            for (int i = 0; i < int'(pw[11:0]); i++) begin
                drd[w] = 1'b1;
                tick();
                e = (exp_dat[w].size() > 0) ? exp_dat[w].pop_front() : 8'h00;
                if (ddo(w) !== e) begin
                    bad++;
                    if (first < 0) first = i;
                end
            end
            drd[w] = 1'b0;
            if (bad != 0) $display("readback first bad index %0d", first);
            chk($sformatf("%s_readback_d%0d", tag, w), 32'(bad), 32'd0);
        end
        tick();
        chk($sformatf("%s_drained_d%0d", tag, w), 32'(pempty(w)), 32'd1);
        occ[w] = 0;
        pcnt[w] = 0;
    endtask

    task automatic frame(string tag, bit nib, int len, logic [15:0] ty, bit bad);
        build(len, 48'($urandom) << 16 | 48'h0000_0000_1234, ty, bad);
        send(nib, 7, -1);
        model_frame();
        ifg();
        check_state(tag);
    endtask

    initial begin
        logic [7:0] last;
        rstn = 1'b0;
        speed = 1'b1;
        rx_dv = 1'b0;
        rx_vld = 1'b0;
        rx_d = 8'h00;
        drd = 2'b00;
        prd = 2'b00;
        model_reset();
        repeat (3) tick();
        for (int w = 0; w < 2; w++) begin
            chk($sformatf("rst_ddout_d%0d", w), 32'(ddo(w)), 32'd0);
            chk($sformatf("rst_pdout_d%0d", w), 32'(pdo(w)), 32'd0);
        end
        check_state("rst");
        rstn = 1'b1;
        repeat (3) tick();

        // Good 64-byte frame with commit latency and empty-read hold.
        build(64, 48'hf0f1f2f3f4f5, 16'h0800, 1'b0);
        last = frm[63];
        send(1'b0, 7, -1);
        tick();
        tick();
        chk("t1_lat_e1", 32'(if0.ptr_fifo_empty), 32'd1);
        tick();
        chk("t1_lat_e2", 32'(if0.ptr_fifo_empty), 32'd0);
        chk("t1_ptr_const", 32'(exp_ptr[0].size()), 32'd0);
        model_frame();
        chk("t1_model_ptr", 32'(exp_ptr[0][0]), 32'h0040);
        ifg();
        check_state("t1");
        drain("t1", 0);
        drain("t1", 1);
        drd[0] = 1'b1;
        tick();
        drd[0] = 1'b0;
        chk("t1_empty_read_hold", 32'(ddo(0)), 32'(last));

        frame("t2_badfcs", 1'b0, 100, 16'h0800, 1'b1);
        drain("t2", 0);
        drain("t2", 1);

        frame("t3_nib_max", 1'b1, 1518, 16'h88f7, 1'b0);
        drain("t3", 0);
        drain("t3", 1);

        frame("t4_runt", 1'b0, 60, 16'h0800, 1'b0);
        drain("t4a", 0);
        drain("t4a", 1);
        frame("t4_giant", 1'b0, 1519, 16'h0800, 1'b0);
        frame("t4_after", 1'b0, 64, 16'h0800, 1'b0);
        drain("t4b", 0);
        drain("t4b", 1);

        // Preamble faults: no SFD lead-in, and eight 0x55 bytes.
        build(64, 48'h0102_0304_0506, 16'h0800, 1'b0);
        send(1'b0, 0, -1);
        ifg();
        check_state("pre0");
        send(1'b1, 8, -1);
        ifg();
        check_state("pre8");

        frame("t5_f1", 1'b0, 1518, 16'h0800, 1'b0);
        frame("t5_f2", 1'b0, 1518, 16'h0800, 1'b0);
        frame("t5_f3", 1'b0, 1518, 16'h0800, 1'b0);
        drain("t5", 0);
        drain("t5", 1);
        frame("t5_resend", 1'b0, 1518, 16'h0800, 1'b0);
        drain("t5r", 0);
        drain("t5r", 1);

        // Reset pulsed mid-frame, released while the frame continues.
        build(80, 48'hAABB_CCDD_EEFF, 16'h0800, 1'b0);
        send(1'b0, 7, 30);
        model_reset();
        ifg();
        check_state("t6_rst");
        frame("t6_next", 1'b1, 64, 16'h0800, 1'b0);
        drain("t6", 0);
        drain("t6", 1);

        for (int k = 0; k < 4; k++) begin
            frame($sformatf("rnd%0d", k), 1'($urandom_range(0, 1)),
                  int'($urandom_range(56, 200)), 16'h0800,
                  1'($urandom_range(0, 1)));
            drain("rnd", 0);
            drain("rnd", 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: observed=timeout expected=completion");
        $fatal(1, "watchdog");
    end
endmodule
